// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/load-store memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } arb_state_t;

  typedef enum logic {
    PORT_IF,
    PORT_D
  } port_id_t;

  typedef logic [0:3][7:0] word_t;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hffff_fffc;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational requester selection for mem_arbiter.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise the data port always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic     if_req,
  input  logic     d_req,
  input  port_id_t last_win,
  output logic     grant,
  output port_id_t port
);

  assign grant = if_req | d_req;

`ifdef MEM_ARB_RR_EN
  // On a tie the port that lost the previous acceptance goes next.
  always_comb begin
    port = PORT_D;
    if (if_req && !d_req) begin
      port = PORT_IF;
    end else if (if_req && d_req && (last_win == PORT_D)) begin
      port = PORT_IF;
    end
  end
`else
  logic unused_last_win;
  assign unused_last_win = (last_win == PORT_D);
  assign port = (if_req && !d_req) ? PORT_IF : PORT_D;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one word-addressable memory between instruction fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin tie-breaking (default: data-port priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned TOP     = 65535
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [31:0]     if_addr,
  output logic            if_done,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [31:0]     d_addr,
  input  logic [0:3][7:0] d_wdata,
  output logic            d_done,
  output logic [0:3][7:0] rdata,
  output logic            err,
  output logic [31:0]     mem_addr,
  output logic [0:3][7:0] mem_wdata,
  output logic            mem_we,
  input  logic [0:3][7:0] mem_rdata
);

  localparam logic [31:0] LAST_OK  = 32'(TOP - 3);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  arb_state_t  state;
  logic [3:0]  cnt;
  port_id_t    lat_port;
  port_id_t    last_win;
  port_id_t    pick_port;
  logic        lat_we;
  logic        range_err;
  logic        grant;
  logic [31:0] sel_addr;

  mem_arb_pick u_pick (
    .if_req   (if_req),
    .d_req    (d_req),
    .last_win (last_win),
    .grant    (grant),
    .port     (pick_port)
  );

  assign sel_addr = (pick_port == PORT_D) ? d_addr : if_addr;

`ifndef MEM_ARB_RR_EN
  assign last_win = PORT_IF;
`endif

  // Range is judged on the requested byte address so a word straddling TOP errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_port  <= PORT_IF;
      lat_we    <= 1'b0;
      range_err <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
`ifdef MEM_ARB_RR_EN
      last_win  <= PORT_IF;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            lat_port  <= pick_port;
            mem_addr  <= sel_addr & WORD_ALIGN_MASK;
            mem_wdata <= (pick_port == PORT_D) ? d_wdata : '0;
            lat_we    <= (pick_port == PORT_D) && d_we;
            range_err <= sel_addr > LAST_OK;
            cnt       <= CNT_INIT;
            state     <= BUSY;
`ifdef MEM_ARB_RR_EN
            last_win  <= pick_port;
`endif
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rdata <= range_err ? '0 : mem_rdata;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign mem_we  = (state == BUSY) && (cnt == '0) && lat_we && !range_err;
  assign if_done = (state == DONE) && (lat_port == PORT_IF);
  assign d_done  = (state == DONE) && (lat_port == PORT_D);
  assign err     = (state == DONE) && range_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, corner sequences,
// latency sweep instances and a randomized run against a transaction model.
module tb_mem_arbiter;

  localparam int          LAT  = 2;
  localparam logic [31:0] TOPV = 32'h0000_FFFF;

  typedef struct {
    logic        ifr;
    logic        dr;
    logic        we;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] wd;
    logic        ep;
    logic [31:0] erd;
    logic        eerr;
    int          ewe;
    logic [31:0] eaddr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_done, d_done, err, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem     [0:16383];
  logic [31:0] ref_mem [0:16383];
  logic        pre_en;
  logic [13:0] pre_idx;
  logic [31:0] pre_val;

  logic        sw_req;
  logic [31:0] sw_addr;
  logic        l1_d_done, l15_d_done, l1_err, l15_err;
  logic [31:0] l1_rdata, l15_rdata, l1_mem_addr, l15_mem_addr;
  logic        l1_unused_if_done, l15_unused_if_done, l1_unused_we, l15_unused_we;
  logic [31:0] l1_unused_wdata, l15_unused_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic        obs_timeout, obs_port, obs_both, obs_err, obs_extra;
  logic [31:0] obs_rd, obs_busy_addr;
  int          obs_lat, obs_we_cnt;
`ifdef MEM_ARB_RR_EN
  logic        ref_last;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(LAT), .TOP(65535)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
    .rdata(rdata), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.LATENCY(1), .TOP(65535)) dut_l1 (
    .clk(clk), .rst(rst),
    .if_req(1'b0), .if_addr(32'h0), .if_done(l1_unused_if_done),
    .d_req(sw_req), .d_we(1'b0), .d_addr(sw_addr), .d_wdata(32'h0), .d_done(l1_d_done),
    .rdata(l1_rdata), .err(l1_err),
    .mem_addr(l1_mem_addr), .mem_wdata(l1_unused_wdata), .mem_we(l1_unused_we),
    .mem_rdata(l1_mem_addr ^ 32'hA5A5_0000)
  );

  mem_arbiter #(.LATENCY(15), .TOP(65535)) dut_l15 (
    .clk(clk), .rst(rst),
    .if_req(1'b0), .if_addr(32'h0), .if_done(l15_unused_if_done),
    .d_req(sw_req), .d_we(1'b0), .d_addr(sw_addr), .d_wdata(32'h0), .d_done(l15_d_done),
    .rdata(l15_rdata), .err(l15_err),
    .mem_addr(l15_mem_addr), .mem_wdata(l15_unused_wdata), .mem_we(l15_unused_we),
    .mem_rdata(l15_mem_addr ^ 32'hA5A5_0000)
  );

  // Memory with combinational read and clocked write, plus a bench preload path.
  assign mem_rdata = mem[mem_addr[15:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[15:2]] <= mem_wdata;
    if (pre_en) mem[pre_idx] <= pre_val;
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic preload(input logic [13:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    ref_mem[idx] = val;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
`ifdef MEM_ARB_RR_EN
    ref_last = 1'b0;
`endif
  endtask

  // One access: present requests for one edge, scramble inputs, then watch for done.
  task automatic applyStimulus(input logic ifr, input logic dr, input logic we,
                               input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd);
    int n;
    bit seen;
    @(negedge clk);
    if_req = ifr; d_req = dr; d_we = we; if_addr = ia; d_addr = da; d_wdata = wd;
    @(posedge clk);
    #1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'($urandom_range(0, 1));
    if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
    obs_busy_addr = mem_addr;
    obs_we_cnt = 0; obs_timeout = 1'b0; obs_rd = '0; obs_err = 1'b0;
    obs_port = 1'b0; obs_both = 1'b0; obs_lat = 0;
    seen = 0; n = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      if (mem_we) obs_we_cnt++;
      if (if_done || d_done) begin
        seen = 1; obs_port = d_done; obs_both = if_done && d_done;
        obs_rd = rdata; obs_err = err; obs_lat = n + 1;
      end else begin
        @(posedge clk);
        n++;
      end
    end
    obs_timeout = !seen;
    @(negedge clk);
    obs_extra = if_done || d_done;
    if (mem_we) obs_we_cnt++;
  endtask

  task automatic checkAccess(input string name, input logic ep, input logic [31:0] erd,
                             input logic eerr, input int ewe, input logic [31:0] eaddr);
    checkOutput({name, " timeout"}, 32'(obs_timeout), 32'd0);
    checkOutput({name, " port"}, 32'(obs_port), 32'(ep));
    checkOutput({name, " both_done"}, 32'(obs_both), 32'd0);
    checkOutput({name, " rdata"}, obs_rd, erd);
    checkOutput({name, " err"}, 32'(obs_err), 32'(eerr));
    checkOutput({name, " latency"}, 32'(obs_lat), 32'(LAT + 1));
    checkOutput({name, " we_cycles"}, 32'(obs_we_cnt), 32'(ewe));
    checkOutput({name, " mem_addr"}, obs_busy_addr, eaddr);
    checkOutput({name, " done_width"}, 32'(obs_extra), 32'd0);
  endtask

  // Transaction-level reference: who wins, what the word was, whether it errors.
  task automatic modelAccess(input logic ifr, input logic dr, input logic we,
                             input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                             output logic ep, output logic [31:0] erd, output logic eerr,
                             output int ewe, output logic [31:0] eaddr);
    logic [31:0] a;
    if (ifr && dr) begin
`ifdef MEM_ARB_RR_EN
      ep = !ref_last;
`else
      ep = 1'b1;
`endif
    end else begin
      ep = dr;
    end
`ifdef MEM_ARB_RR_EN
    ref_last = ep;
`endif
    a     = ep ? da : ia;
    eaddr = {a[31:2], 2'b00};
    eerr  = (64'(a) + 64'd3) > 64'(TOPV);
    erd   = eerr ? 32'h0 : ref_mem[a[15:2]];
    ewe   = (ep && we && !eerr) ? 1 : 0;
    if (ewe == 1) ref_mem[a[15:2]] = wd;
  endtask

  function automatic logic [31:0] pickAddr();
    int s;
    s = $urandom_range(0, 9);
    if (s < 6)      return 32'($urandom_range(0, 255));
    else if (s < 8) return 32'h0000_FFF0 + 32'($urandom_range(0, 15));
    else if (s < 9) return 32'h0001_0000 + 32'($urandom_range(0, 65535));
    else            return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
  endfunction

  initial begin
    vec_t        tbl [11];
    logic        ep, eerr;
    logic [31:0] erd, eaddr;
    int          ewe, k, got, c1, c15, late_done;
    logic        r_ifr, r_dr, r_we;
    logic [31:0] r_ia, r_da, r_wd;
    logic        seq_port [3];
    int          seq_at   [3];
    logic [31:0] seq_rd   [3];
    logic        exp_seq  [3];
    int          t1 [2];
    int          t15 [2];
    logic [31:0] rd1, rd15;
    logic        e1, e15;

    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    pre_en = 1'b0; pre_idx = '0; pre_val = '0;
    sw_req = 1'b0; sw_addr = '0;
`ifdef MEM_ARB_RR_EN
    ref_last = 1'b0;
`endif

    #1 rst = 1'b1;
    #2;
    checkOutput("reset if_done", 32'(if_done), 32'd0);
    checkOutput("reset d_done", 32'(d_done), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    checkOutput("reset rdata", rdata, 32'd0);
    checkOutput("reset mem_addr", mem_addr, 32'd0);
    checkOutput("reset mem_wdata", mem_wdata, 32'd0);
    checkOutput("reset mem_we", 32'(mem_we), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 64; i++) preload(14'(i), $urandom);
    for (int i = 0; i < 4; i++) preload(14'(16380 + i), $urandom);
    preload(14'd4, 32'h1122_3344);
    preload(14'd8, 32'h0);
    preload(14'd9, 32'hCAFE_F00D);
    preload(14'h3FFF, 32'h5A5A_5A5A);

    // Latency sweep: LATENCY=1 and 15 instances with requests held high.
    t1 = '{-1, -1}; t15 = '{-1, -1}; c1 = 0; c15 = 0;
    rd1 = '0; rd15 = '0; e1 = 1'b1; e15 = 1'b1;
    @(negedge clk);
    sw_req = 1'b1; sw_addr = 32'h1236;
    @(posedge clk);
    k = 0;
    while ((c1 < 2 || c15 < 2) && k < 45) begin
      @(negedge clk);
      if (l1_d_done && c1 < 2) begin
        t1[c1] = k; if (c1 == 0) begin rd1 = l1_rdata; e1 = l1_err; end c1++;
      end
      if (l15_d_done && c15 < 2) begin
        t15[c15] = k; if (c15 == 0) begin rd15 = l15_rdata; e15 = l15_err; end c15++;
      end
      @(posedge clk);
      k++;
    end
    sw_req = 1'b0;
    checkOutput("lat1 first done", 32'(t1[0]), 32'd1);
    checkOutput("lat1 spacing", 32'(t1[1] - t1[0]), 32'd3);
    checkOutput("lat1 rdata", rd1, 32'hA5A5_1234);
    checkOutput("lat1 err", 32'(e1), 32'd0);
    checkOutput("lat15 first done", 32'(t15[0]), 32'd15);
    checkOutput("lat15 spacing", 32'(t15[1] - t15[0]), 32'd17);
    checkOutput("lat15 rdata", rd15, 32'hA5A5_1234);
    checkOutput("lat15 err", 32'(e15), 32'd0);
    repeat (20) @(negedge clk);

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h13,    32'h0,     32'h0,         1'b0, 32'h1122_3344, 1'b0, 0, 32'h10};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'h0,     32'h20,    32'hAABB_CCDD, 1'b1, 32'h0,         1'b0, 1, 32'h20};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h20,    32'h0,     32'h0,         1'b0, 32'hAABB_CCDD, 1'b0, 0, 32'h20};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,     32'h22,    32'h0,         1'b1, 32'hAABB_CCDD, 1'b0, 0, 32'h20};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'h0,     32'hFFFE,  32'h1234_5678, 1'b1, 32'h0,         1'b1, 0, 32'hFFFC};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,     32'hFFFC,  32'h0,         1'b1, 32'h5A5A_5A5A, 1'b0, 0, 32'hFFFC};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'hFFFD,  32'h0,     32'h0,         1'b0, 32'h0,         1'b1, 0, 32'hFFFC};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'h0,     32'h10,    32'h0102_0304, 1'b1, 32'h1122_3344, 1'b0, 1, 32'h10};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h11,    32'h0,     32'h0,         1'b0, 32'h0102_0304, 1'b0, 0, 32'h10};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,     32'h10000, 32'h0,         1'b1, 32'h0,         1'b1, 0, 32'h10000};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 32'h24,    32'h24,    32'hFFFF_FFFF, 1'b0, 32'hCAFE_F00D, 1'b0, 0, 32'h24};

    for (int i = 0; i < 11; i++) begin
      modelAccess(tbl[i].ifr, tbl[i].dr, tbl[i].we, tbl[i].ia, tbl[i].da, tbl[i].wd,
                  ep, erd, eerr, ewe, eaddr);
      applyStimulus(tbl[i].ifr, tbl[i].dr, tbl[i].we, tbl[i].ia, tbl[i].da, tbl[i].wd);
      checkAccess($sformatf("vec%0d", i), tbl[i].ep, tbl[i].erd, tbl[i].eerr, tbl[i].ewe, tbl[i].eaddr);
    end
    checkOutput("store landed 0x20", mem[8], 32'hAABB_CCDD);
    checkOutput("oob store no write", mem[16383], 32'h5A5A_5A5A);

    // Both requesters held high across three accesses from reset.
    applyReset();
`ifdef MEM_ARB_RR_EN
    exp_seq = '{1'b1, 1'b0, 1'b1};
`else
    exp_seq = '{1'b1, 1'b1, 1'b1};
`endif
    seq_port = '{1'b0, 1'b0, 1'b0}; seq_at = '{-1, -1, -1}; seq_rd = '{32'h0, 32'h0, 32'h0};
    @(negedge clk);
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 32'h40; d_addr = 32'h44;
    @(posedge clk);
    k = 0; got = 0;
    while (got < 3 && k < 40) begin
      @(negedge clk);
      if (if_done || d_done) begin
        seq_port[got] = d_done; seq_at[got] = k; seq_rd[got] = rdata; got++;
        if (got == 3) begin if_req = 1'b0; d_req = 1'b0; end
      end
      @(posedge clk);
      k++;
    end
    if_req = 1'b0; d_req = 1'b0;
    checkOutput("tie count", 32'(got), 32'd3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("tie%0d port", i), 32'(seq_port[i]), 32'(exp_seq[i]));
      checkOutput($sformatf("tie%0d time", i), 32'(seq_at[i]), 32'(LAT + i * (LAT + 2)));
      checkOutput($sformatf("tie%0d rdata", i), seq_rd[i], exp_seq[i] ? ref_mem[17] : ref_mem[16]);
    end

    // Reset lands while a store sits on its commit cycle.
    preload(14'd12, 32'h0BAD_BEEF);
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'h9988_7766;
    @(posedge clk);
    #1 d_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst we before", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst mem_we", 32'(mem_we), 32'd0);
    checkOutput("midrst mem_addr", mem_addr, 32'd0);
    checkOutput("midrst mem_wdata", mem_wdata, 32'd0);
    checkOutput("midrst rdata", rdata, 32'd0);
    late_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (if_done || d_done) late_done++;
    end
    rst = 1'b0;
`ifdef MEM_ARB_RR_EN
    ref_last = 1'b0;
`endif
    repeat (4) begin
      @(negedge clk);
      if (if_done || d_done) late_done++;
    end
    checkOutput("midrst no done", 32'(late_done), 32'd0);
    checkOutput("midrst word kept", mem[12], 32'h0BAD_BEEF);
    modelAccess(1'b0, 1'b1, 1'b1, 32'h0, 32'h30, 32'h1357_2468, ep, erd, eerr, ewe, eaddr);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'h30, 32'h1357_2468);
    checkAccess("midrst recover", ep, erd, eerr, ewe, eaddr);

    // Randomized traffic against the transaction model.
    applyReset();
    for (int t = 0; t < 150; t++) begin
      k = $urandom_range(1, 3);
      r_ifr = k[0]; r_dr = k[1]; r_we = 1'($urandom_range(0, 1));
      r_ia = pickAddr(); r_da = pickAddr(); r_wd = $urandom;
      modelAccess(r_ifr, r_dr, r_we, r_ia, r_da, r_wd, ep, erd, eerr, ewe, eaddr);
      applyStimulus(r_ifr, r_dr, r_we, r_ia, r_da, r_wd);
      checkAccess($sformatf("rand%0d", t), ep, erd, eerr, ewe, eaddr);
    end

    repeat (2) @(negedge clk);
    for (int i = 0; i < 64; i++) checkOutput($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
    for (int i = 16380; i < 16384; i++) checkOutput($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer that shares the single word-addressable `memory` instance between the instruction-fetch unit and the load/store unit. It accepts one request at a time and chooses between simultaneous requesters. It drives the memory address, write data and write enable for a configurable number of wait-state cycles, then captures read data and returns it with a one-cycle `done` pulse. It sits between the CPU front/back ends and `memory`, and is the only driver of the memory's `addr`, `data_in` and `we`.

## Interface
- `LATENCY`, 2: memory occupancy per access in cycles; legal range 1..15.
- `TOP`, 65535: highest legal byte address; must match the `top` of the attached memory.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; level, sampled only in IDLE.
- `if_addr`  in  32  fetch byte address.
- `if_done`  out  1  one-cycle pulse; fetch result is valid.
- `d_req`  in  1  data request; level, sampled only in IDLE.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  8 x [0:3]  store bytes, in byte order 0..3.
- `d_done`  out  1  one-cycle pulse; data result is valid.
- `rdata`  out  8 x [0:3]  read word for the port whose done is high.
- `err`  out  1  qualifies `done`; the access was out of range.
- `mem_addr`  out  32  to `memory.addr`; bits [1:0] are always 0.
- `mem_wdata`  out  8 x [0:3]  to `memory.data_in`.
- `mem_we`  out  1  to `memory.we`.
- `mem_rdata`  in  8 x [0:3]  from `memory.data_out` (combinational read).

## Operation
- FSM states are IDLE, BUSY and DONE; the reset state is IDLE.
- **IDLE**
  - If any request is high, pick the winner.
  - Latch the winner's port id, address (with bits [1:0] cleared), write flag and write data.
  - Load the counter `cnt <= LATENCY-1` and go to BUSY.
  - If no request is high, stay in IDLE.
- **BUSY**
  - `mem_addr` and `mem_wdata` are driven from the latched values.
  - When `cnt != 0`: decrement `cnt`.
  - When `cnt == 0`:
    - `mem_we = latched_we & ~range_err` for this cycle only.
    - Register `mem_rdata` into `rdata`; register 0 instead if `range_err` is set.
    - Go to DONE.
- **DONE**
  - Assert the winner's `done` and drive `err = range_err`.
  - Go to IDLE.
- `range_err` = latched address > `TOP - 3`. An erroring store never asserts `mem_we`.
- A store returns the old word in `rdata`, because read data is captured on the same edge that the write commits.
- **Requester rule:** a requester drops `req` on the edge where it sees `done`. If `req` is still high in the following IDLE cycle, that is a new request.
- Request inputs need not be held after the acceptance edge.
- Simultaneous requests are resolved by arbitration; see Configuration.

## Timing
- Acceptance edge E0 is the IDLE→BUSY transition.
- The write commits at edge E0+LATENCY.
- `done`, `rdata` and `err` are valid in the cycle after E0+LATENCY.
- Back-to-back throughput is one access per LATENCY+2 cycles.
- `mem_we`, `if_done`, `d_done` and `err` are decoded from registered state/counter flops, with no combinational path from the request inputs.
- **Reset values:** state IDLE, `cnt` 0, all dones 0, `err` 0, `rdata` all bytes 0, `mem_addr` 0, `mem_wdata` 0, `mem_we` 0, last-winner = fetch.
- **Reset mid-operation:**
  - Outputs clear immediately.
  - The in-flight access is dropped and no `done` is issued.
  - A store commits only if its commit edge preceded the reset.

## Configuration
- Macro `MEM_ARB_RR_EN`:
  - **Defined:** round-robin. On simultaneous requests, the port that did not win last wins. The last-winner flop updates on every acceptance.
  - **Undefined:** fixed priority, data port always wins. The last-winner flop is not built.
- Both modes give the same first simultaneous outcome after reset: data wins.

## Structure
- Package `mem_arb_pkg` holds:
  - `arb_state_t` (IDLE/BUSY/DONE)
  - `port_id_t` (PORT_IF/PORT_D)
  - `word_t` (4 x 8-bit byte array)
  - `WORD_ALIGN_MASK = 32'hffff_fffc`
- One sub-module, `mem_arb_pick`. It is combinational: inputs are the two requests and last-winner; outputs are grant and port id. It contains the `MEM_ARB_RR_EN` selection logic.

## Test plan
- **Single load.** LATENCY=2, preload word at 0x10 = {11,22,33,44}. Pulse `if_req` with `if_addr`=0x13. Expected: `mem_addr`=0x10 during BUSY; `if_done` high 3 cycles after E0; `rdata`={11,22,33,44}; `err`=0.
- **Store then load.** `d_we`=1, `d_addr`=0x20, `d_wdata`={AA,BB,CC,DD}. Expected: `mem_we` high exactly 1 cycle; a subsequent load of 0x20 returns {AA,BB,CC,DD}; the store's own `rdata` is the old value 0.
- **Simultaneous requests.** `if_req` and `d_req` held high for 3 accesses:
  - Without `MEM_ARB_RR_EN`: D, D, D.
  - With `MEM_ARB_RR_EN`: D, IF, D.
- **Out of range.** `TOP`=0xFFFF, store to 0xFFFE. Expected: `mem_we` never high; `d_done` with `err`=1; `rdata`=0; memory unchanged.
- **Reset mid-BUSY.** Assert `rst` one cycle after E0 of a store. Expected: outputs 0 immediately, no `done`, target word unchanged, the next request is served normally.
- **Latency sweep.** LATENCY=1 and LATENCY=15. Expected: `done` exactly LATENCY+1 cycles after E0; back-to-back spacing LATENCY+2.
